// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: access FSM states and the
// E/M and M/W pipeline-register payloads.
package mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic              pcsrc;
        logic              regwrite;
        logic              memtoreg;
        logic              memwrite;
        logic [REG_W-1:0]  rd;
        logic [WORD_W-1:0] alu_result;
        logic [WORD_W-1:0] write_data;
    } em_bundle_t;

    typedef struct packed {
        logic              pcsrc;
        logic              regwrite;
        logic              memtoreg;
        logic              fault;
        logic [REG_W-1:0]  rd;
        logic [WORD_W-1:0] read_data;
        logic [WORD_W-1:0] alu_out;
    } mw_bundle_t;

    localparam int unsigned EM_W = $bits(em_bundle_t);
    localparam int unsigned MW_W = $bits(mw_bundle_t);

    // Bits cleared when a bubble is loaded into M/W; data fields are held.
    localparam mw_bundle_t MW_CTRL_MASK = '{
        pcsrc:     1'b1,
        regwrite:  1'b1,
        memtoreg:  1'b1,
        fault:     1'b1,
        rd:        '0,
        read_data: '0,
        alu_out:   '0
    };

    function automatic logic is_mem_op(input em_bundle_t b);
        return b.memtoreg | b.memwrite;
    endfunction

endpackage

// File: rtl/mem_stage_reg.sv
// Pipeline register with async reset, load enable and bubble load
// (bubble clears the CTRL_MASK bits and holds everything else).
module stage_reg #(
    parameter int unsigned W         = 8,
    parameter logic [W-1:0] CTRL_MASK = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (bubble) begin
            q <= q & ~CTRL_MASK;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: E/M register, request/acknowledge data-bus FSM and M/W
// register. Optional alignment check is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCSrcE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             MemWriteE,
    input  logic [3:0]       RdE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] WriteDataE,
    output logic             StallM,
    output logic             RegWriteM,
    output logic [3:0]       RdM,
    output logic [WIDTH-1:0] ALUResultM,
    output logic             DReq,
    output logic             DWe,
    output logic [WIDTH-1:0] DAddr,
    output logic [WIDTH-1:0] DWData,
    input  logic             DAck,
    input  logic [WIDTH-1:0] DRData,
    output logic             PCSrcW,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic [3:0]       RdW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [WIDTH-1:0] ALUOutW,
    output logic             FaultW
);

    em_bundle_t        em_d;
    em_bundle_t        em_q;
    mw_bundle_t        mw_d;
    mw_bundle_t        mw_q;
    mem_state_t        state;
    mem_state_t        state_next;
    logic              misalign;
    logic              mem_op;
    logic              stall;
    logic              capture;
    logic              dreq;
    logic [WORD_W-1:0] rbuf;

    assign em_d = '{
        pcsrc:      PCSrcE,
        regwrite:   RegWriteE,
        memtoreg:   MemtoRegE,
        memwrite:   MemWriteE,
        rd:         RdE,
        alu_result: WORD_W'(ALUResultE),
        write_data: WORD_W'(WriteDataE)
    };

    // E/M holds while the access is outstanding.
    stage_reg #(
        .W         (EM_W),
        .CTRL_MASK ('0)
    ) u_em_reg (
        .clk    (clk),
        .reset  (reset),
        .en     (~stall),
        .bubble (1'b0),
        .d      (em_d),
        .q      (em_q)
    );

    // A misaligned access bypasses the bus and leaves M as a faulted op.
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = is_mem_op(em_q) & (em_q.alu_result[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign mem_op = is_mem_op(em_q) & ~misalign;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (mem_op) state_next = REQ;
            REQ:     if (DAck)   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall   = 1'b0;
        capture = 1'b0;
        if (mem_op && (state != DONE)) stall = 1'b1;
        if ((state == REQ) && DAck)    capture = 1'b1;
    end

    // Bus request flop mirrors REQ; read buffer catches data on acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dreq <= 1'b0;
            rbuf <= '0;
        end else begin
            dreq <= (state_next == REQ);
            if (capture) rbuf <= WORD_W'(DRData);
        end
    end

    always_comb begin
        mw_d           = '0;
        mw_d.pcsrc     = em_q.pcsrc;
        mw_d.regwrite  = em_q.regwrite & ~misalign;
        mw_d.memtoreg  = em_q.memtoreg;
        mw_d.fault     = misalign;
        mw_d.rd        = em_q.rd;
        mw_d.read_data = (em_q.memtoreg & ~misalign) ? rbuf : '0;
        mw_d.alu_out   = em_q.alu_result;
    end

    // M/W takes a bubble on every stalled cycle.
    stage_reg #(
        .W         (MW_W),
        .CTRL_MASK (MW_CTRL_MASK)
    ) u_mw_reg (
        .clk    (clk),
        .reset  (reset),
        .en     (1'b1),
        .bubble (stall),
        .d      (mw_d),
        .q      (mw_q)
    );

    assign StallM     = stall;
    assign RegWriteM  = em_q.regwrite;
    assign RdM        = em_q.rd;
    assign ALUResultM = WIDTH'(em_q.alu_result);

    assign DReq   = dreq;
    assign DWe    = em_q.memwrite;
    assign DAddr  = WIDTH'(em_q.alu_result);
    assign DWData = WIDTH'(em_q.write_data);

    assign PCSrcW    = mw_q.pcsrc;
    assign RegWriteW = mw_q.regwrite;
    assign MemtoRegW = mw_q.memtoreg;
    assign RdW       = mw_q.rd;
    assign ReadDataW = WIDTH'(mw_q.read_data);
    assign ALUOutW   = WIDTH'(mw_q.alu_out);
    assign FaultW    = mw_q.fault;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a timing-level model.
module tb_mem_stage;

    localparam int unsigned W = 32;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         PCSrcE, RegWriteE, MemtoRegE, MemWriteE;
    logic [3:0]   RdE;
    logic [W-1:0] ALUResultE, WriteDataE;
    logic         StallM, RegWriteM;
    logic [3:0]   RdM;
    logic [W-1:0] ALUResultM;
    logic         DReq, DWe, DAck;
    logic [W-1:0] DAddr, DWData, DRData;
    logic         PCSrcW, RegWriteW, MemtoRegW, FaultW;
    logic [3:0]   RdW;
    logic [W-1:0] ReadDataW, ALUOutW;

    mem_stage #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrcE     (PCSrcE),
        .RegWriteE  (RegWriteE),
        .MemtoRegE  (MemtoRegE),
        .MemWriteE  (MemWriteE),
        .RdE        (RdE),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .StallM     (StallM),
        .RegWriteM  (RegWriteM),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .DReq       (DReq),
        .DWe        (DWe),
        .DAddr      (DAddr),
        .DWData     (DWData),
        .DAck       (DAck),
        .DRData     (DRData),
        .PCSrcW     (PCSrcW),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .RdW        (RdW),
        .ReadDataW  (ReadDataW),
        .ALUOutW    (ALUOutW),
        .FaultW     (FaultW)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pc;
        logic        rw;
        logic        m2r;
        logic        mw;
        logic [3:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        int          k;
    } ins_t;

    typedef struct packed {
        logic        pc;
        logic        rw;
        logic [3:0]  rd;
        logic [31:0] alu;
        logic        exp_pc;
        logic        exp_rw;
        logic [3:0]  exp_rd;
        logic [31:0] exp_alu;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_e(input ins_t i);
        PCSrcE     = i.pc;
        RegWriteE  = i.rw;
        MemtoRegE  = i.m2r;
        MemWriteE  = i.mw;
        RdE        = i.rd;
        ALUResultE = i.alu;
        WriteDataE = i.wd;
    endtask

    task automatic check_all_zero(input string p);
        check1({p, "_stall"}, StallM, 1'b0);
        check1({p, "_dreq"}, DReq, 1'b0);
        check1({p, "_regwrite_m"}, RegWriteM, 1'b0);
        check4({p, "_rd_m"}, RdM, 4'd0);
        check32({p, "_alu_m"}, ALUResultM, 32'd0);
        check1({p, "_pcsrc_w"}, PCSrcW, 1'b0);
        check1({p, "_regwrite_w"}, RegWriteW, 1'b0);
        check1({p, "_memtoreg_w"}, MemtoRegW, 1'b0);
        check4({p, "_rd_w"}, RdW, 4'd0);
        check32({p, "_rdata_w"}, ReadDataW, 32'd0);
        check32({p, "_aluout_w"}, ALUOutW, 32'd0);
        check1({p, "_fault_w"}, FaultW, 1'b0);
    endtask

    // Single load/store with the acknowledge in the k-th request cycle.
    task automatic mem_seq(input string nm, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int k);
        int   dreq_cnt = 0;
        int   stall_cnt = 0;
        int   w_win = 0;
        ins_t i;
        i     = '0;
        i.rw  = ~we;
        i.m2r = ~we;
        i.mw  = we;
        i.rd  = 4'd7;
        i.alu = addr;
        i.wd  = wdata;
        @(negedge clk);
        drive_e(i);
        @(negedge clk);
        drive_e('0);
        for (int win = 1; win <= k + 6; win++) begin
            if (StallM) stall_cnt++;
            if (DReq) begin
                dreq_cnt++;
                check32({nm, "_daddr"}, DAddr, addr);
                check1({nm, "_dwe"}, DWe, we);
                check32({nm, "_dwdata"}, DWData, wdata);
            end
            DAck   = DReq && (dreq_cnt == k);
            DRData = DAck ? rdata : (32'hBAD0_0000 | 32'(win));
            if (w_win == 0 && ALUOutW == addr && RdW == 4'd7) begin
                w_win = win;
                check32({nm, "_rdata_w"}, ReadDataW, we ? 32'd0 : rdata);
                check1({nm, "_regwrite_w"}, RegWriteW, ~we);
                check1({nm, "_memtoreg_w"}, MemtoRegW, ~we);
                check1({nm, "_fault_w"}, FaultW, 1'b0);
            end
            @(negedge clk);
        end
        DAck = 1'b0;
        check_int({nm, "_dreq_cycles"}, dreq_cnt, k);
        check_int({nm, "_stall_cycles"}, stall_cnt, k + 1);
        check_int({nm, "_w_window"}, w_win, k + 3);
    endtask

    // Load followed immediately by an ALU op held upstream during the stall.
    task automatic b2b();
        ins_t ld;
        ins_t al;
        int   win_ld = 0;
        int   win_al = 0;
        int   n_ld = 0;
        int   n_al = 0;
        logic prev_stall = 1'b1;
        logic presenting = 1'b0;
        ld     = '0;
        ld.rw  = 1'b1;
        ld.m2r = 1'b1;
        ld.rd  = 4'd9;
        ld.alu = 32'h300;
        al     = '0;
        al.rw  = 1'b1;
        al.rd  = 4'd5;
        al.alu = 32'h55;
        @(negedge clk);
        drive_e(ld);
        @(negedge clk);
        drive_e(al);
        presenting = 1'b1;
        for (int win = 1; win <= 8; win++) begin
            if (presenting && !prev_stall) begin
                drive_e('0);
                presenting = 1'b0;
            end
            if (win == 4) begin
                check4("b2b_alu_in_m_rd", RdM, 4'd5);
                check1("b2b_alu_in_m_rw", RegWriteM, 1'b1);
            end
            if (MemtoRegW && RdW == 4'd9) begin
                n_ld++;
                win_ld = win;
                check32("b2b_load_rdata", ReadDataW, 32'hCAFE_F00D);
            end
            if (RegWriteW && !MemtoRegW && RdW == 4'd5) begin
                n_al++;
                win_al = win;
                check32("b2b_alu_out", ALUOutW, 32'h55);
            end
            DAck       = DReq;
            DRData     = 32'hCAFE_F00D;
            prev_stall = StallM;
            @(negedge clk);
        end
        DAck = 1'b0;
        check_int("b2b_load_count", n_ld, 1);
        check_int("b2b_alu_count", n_al, 1);
        check_int("b2b_load_window", win_ld, 4);
        check_int("b2b_alu_after_load", win_al, win_ld + 1);
    endtask

    task automatic reset_mid_req();
        ins_t ld;
        ld     = '0;
        ld.rw  = 1'b1;
        ld.m2r = 1'b1;
        ld.rd  = 4'd11;
        ld.alu = 32'h400;
        @(negedge clk);
        drive_e(ld);
        @(negedge clk);
        drive_e('0);
        @(negedge clk);
        check1("rst_pre_dreq", DReq, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        reset  = 1'b0;
        DAck   = 1'b1;
        DRData = 32'h5555_AAAA;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            DAck = 1'b0;
            check1("rst_late_dreq", DReq, 1'b0);
            check1("rst_late_stall", StallM, 1'b0);
            check1("rst_late_regwrite_w", RegWriteW, 1'b0);
            check1("rst_late_memtoreg_w", MemtoRegW, 1'b0);
            check32("rst_late_rdata_w", ReadDataW, 32'd0);
        end
    endtask

    function automatic ins_t rand_ins();
        ins_t i;
        int   kind;
        kind  = int'($urandom_range(3, 0));
        i     = '0;
        i.pc  = 1'($urandom);
        i.rw  = 1'($urandom);
        i.rd  = 4'($urandom);
        i.alu = $urandom;
        i.wd  = $urandom;
        i.k   = int'($urandom_range(3, 1));
        if ($urandom_range(3, 0) != 0) i.alu[1:0] = 2'b00;
        if (kind == 1) begin
            i.m2r = 1'b1;
            i.rw  = 1'b1;
        end else if (kind == 2) begin
            i.mw = 1'b1;
            i.rw = 1'b0;
        end
        return i;
    endfunction

    // Model: a memory op entering M stalls for k+1 cycles, requests on cycles
    // 1..k after entry and leaves one cycle later; anything else leaves at once.
    task automatic random_run(input int ncyc);
        ins_t        m_i;
        ins_t        e_i;
        int          t;
        logic [31:0] cap;
        logic        w_pc, w_rw, w_m2r, w_f, w_real, w_chk_rd;
        logic [3:0]  w_rd;
        logic [31:0] w_rdata, w_alu;
        logic        memop, mis, realm, exp_stall, exp_dreq, ack;
        @(negedge clk);
        reset = 1'b1;
        drive_e('0);
        DAck = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        m_i      = '0;
        t        = 0;
        cap      = '0;
        w_pc     = 1'b0;
        w_rw     = 1'b0;
        w_m2r    = 1'b0;
        w_f      = 1'b0;
        w_real   = 1'b0;
        w_chk_rd = 1'b0;
        w_rd     = '0;
        w_rdata  = '0;
        w_alu    = '0;
        e_i      = rand_ins();
        for (int c = 0; c < ncyc; c++) begin
            memop     = m_i.m2r | m_i.mw;
            mis       = ALIGN_EN && memop && (m_i.alu[1:0] != 2'b00);
            realm     = memop && !mis;
            exp_stall = realm && (t <= m_i.k);
            exp_dreq  = realm && (t >= 1) && (t <= m_i.k);
            check1("rnd_stall", StallM, exp_stall);
            check1("rnd_dreq", DReq, exp_dreq);
            check1("rnd_regwrite_m", RegWriteM, m_i.rw);
            check4("rnd_rd_m", RdM, m_i.rd);
            check32("rnd_alu_m", ALUResultM, m_i.alu);
            check1("rnd_pcsrc_w", PCSrcW, w_pc);
            check1("rnd_regwrite_w", RegWriteW, w_rw);
            check1("rnd_memtoreg_w", MemtoRegW, w_m2r);
            check1("rnd_fault_w", FaultW, w_f);
            if (w_real) begin
                check4("rnd_rd_w", RdW, w_rd);
                check32("rnd_aluout_w", ALUOutW, w_alu);
                if (w_chk_rd) check32("rnd_rdata_w", ReadDataW, w_rdata);
            end
            if (exp_dreq) begin
                check1("rnd_dwe", DWe, m_i.mw);
                check32("rnd_daddr", DAddr, m_i.alu);
                check32("rnd_dwdata", DWData, m_i.wd);
            end
            ack    = exp_dreq && (t == m_i.k);
            DAck   = ack | (!exp_dreq && ($urandom_range(3, 0) == 0));
            DRData = $urandom;
            if (ack) cap = DRData;
            drive_e(e_i);
            @(posedge clk);
            if (exp_stall) begin
                w_pc   = 1'b0;
                w_rw   = 1'b0;
                w_m2r  = 1'b0;
                w_f    = 1'b0;
                w_real = 1'b0;
                t++;
            end else begin
                w_pc     = m_i.pc;
                w_rw     = m_i.rw && !mis;
                w_m2r    = m_i.m2r;
                w_f      = mis;
                w_rd     = m_i.rd;
                w_alu    = m_i.alu;
                w_real   = 1'b1;
                w_chk_rd = memop;
                w_rdata  = (m_i.m2r && !mis) ? cap : 32'd0;
                m_i      = e_i;
                t        = 0;
                e_i      = rand_ins();
            end
            @(negedge clk);
        end
        DAck = 1'b0;
    endtask

    vec_t vecs [5];

    initial begin
        reset  = 1'b1;
        DAck   = 1'b0;
        DRData = '0;
        drive_e('0);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        vecs[0] = '{pc: 1'b0, rw: 1'b1, rd: 4'd3,  alu: 32'h0000_0010,
                    exp_pc: 1'b0, exp_rw: 1'b1, exp_rd: 4'd3,  exp_alu: 32'h0000_0010};
        vecs[1] = '{pc: 1'b1, rw: 1'b0, rd: 4'd15, alu: 32'hFFFF_FFFF,
                    exp_pc: 1'b1, exp_rw: 1'b0, exp_rd: 4'd15, exp_alu: 32'hFFFF_FFFF};
        vecs[2] = '{pc: 1'b0, rw: 1'b1, rd: 4'd0,  alu: 32'h8000_0000,
                    exp_pc: 1'b0, exp_rw: 1'b1, exp_rd: 4'd0,  exp_alu: 32'h8000_0000};
        vecs[3] = '{pc: 1'b1, rw: 1'b1, rd: 4'd5,  alu: 32'h0000_0003,
                    exp_pc: 1'b1, exp_rw: 1'b1, exp_rd: 4'd5,  exp_alu: 32'h0000_0003};
        vecs[4] = '{pc: 1'b0, rw: 1'b0, rd: 4'd9,  alu: 32'h1234_5678,
                    exp_pc: 1'b0, exp_rw: 1'b0, exp_rd: 4'd9,  exp_alu: 32'h1234_5678};

        for (int v = 0; v < 5; v++) begin
            ins_t i;
            i     = '0;
            i.pc  = vecs[v].pc;
            i.rw  = vecs[v].rw;
            i.rd  = vecs[v].rd;
            i.alu = vecs[v].alu;
            @(negedge clk);
            drive_e(i);
            @(negedge clk);
            drive_e('0);
            check1("alu_stall_m", StallM, 1'b0);
            check1("alu_regwrite_m", RegWriteM, vecs[v].exp_rw);
            check4("alu_rd_m", RdM, vecs[v].exp_rd);
            check32("alu_result_m", ALUResultM, vecs[v].exp_alu);
            @(negedge clk);
            check1("alu_stall_w", StallM, 1'b0);
            check1("alu_pcsrc_w", PCSrcW, vecs[v].exp_pc);
            check1("alu_regwrite_w", RegWriteW, vecs[v].exp_rw);
            check1("alu_memtoreg_w", MemtoRegW, 1'b0);
            check4("alu_rd_w", RdW, vecs[v].exp_rd);
            check32("alu_out_w", ALUOutW, vecs[v].exp_alu);
            check1("alu_fault_w", FaultW, 1'b0);
        end

        mem_seq("load", 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2);
        mem_seq("store", 1'b1, 32'h200, 32'h1234, 32'h0, 1);
        mem_seq("load_k3", 1'b0, 32'h104, 32'h0, 32'h0F0F_0F0F, 3);
        b2b();
        reset_mid_req();
        mem_seq("post_rst_load", 1'b0, 32'h500, 32'h0, 32'h0BAD_CAFE, 1);

`ifdef MEM_ALIGN_CHECK_EN
        begin
            ins_t ld;
            ld     = '0;
            ld.rw  = 1'b1;
            ld.m2r = 1'b1;
            ld.rd  = 4'd12;
            ld.alu = 32'h102;
            @(negedge clk);
            drive_e(ld);
            @(negedge clk);
            drive_e('0);
            check1("align_dreq", DReq, 1'b0);
            check1("align_stall", StallM, 1'b0);
            @(negedge clk);
            check1("align_dreq_w", DReq, 1'b0);
            check1("align_fault_w", FaultW, 1'b1);
            check1("align_regwrite_w", RegWriteW, 1'b0);
            check32("align_rdata_w", ReadDataW, 32'd0);
            check4("align_rd_w", RdW, 4'd12);
            @(negedge clk);
            check1("align_fault_clear", FaultW, 1'b0);
        end
`endif

        random_run(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
